// File: rtl/shift_key_ctrl.sv
// Key-driven shift controller: sequences a message through a rotating shift key
// and registers per-byte controls for the shift stage. Optional SHIFT_KEY_CTRL_BACKPRESSURE_EN adds pipe_stall.
module shift_key_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_wr,
  input  logic [2:0] key_addr,
  input  logic [2:0] key_data,
  input  logic [2:0] key_len,
  input  logic       start,
  input  logic       mode_in,
  input  logic [7:0] msg_len,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
`ifdef SHIFT_KEY_CTRL_BACKPRESSURE_EN
  input  logic       pipe_stall,
`endif
  output logic       pipe_en,
  output logic       pipe_shift_en,
  output logic       pipe_mode,
  output logic       pipe_upper,
  output logic       pipe_lower,
  output logic [2:0] pipe_shift_amt,
  output logic [7:0] pipe_data,
  output logic       busy,
  output logic       done,
  output logic [1:0] state_dbg
);

  // Handshake: a byte transfers on any rising edge where in_valid && in_ready;
  // in_valid may be raised freely, in_ready depends only on state (and stall).
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t     state_q, state_d;
  logic [2:0] key_q [8];
  logic [2:0] key_len_q;
  logic [2:0] key_idx_q;
  logic [7:0] msg_len_q;
  logic [7:0] byte_cnt_q;
  logic       mode_q;

  logic accept;
  logic honour_start;
  logic last_byte;
  logic is_upper;
  logic is_lower;

`ifdef SHIFT_KEY_CTRL_BACKPRESSURE_EN
  assign in_ready = (state_q == S_RUN) && !pipe_stall;
`else
  assign in_ready = (state_q == S_RUN);
`endif

  assign accept       = in_valid && in_ready;
  assign honour_start = (state_q == S_IDLE) && start && (msg_len != 8'd0);
  assign last_byte    = (byte_cnt_q + 8'd1) == msg_len_q;
  assign is_upper     = (in_data >= 8'd65) && (in_data <= 8'd90);
  assign is_lower     = (in_data >= 8'd97) && (in_data <= 8'd122);

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign state_dbg = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (honour_start) state_d = S_RUN;
      S_RUN:   if (accept && last_byte) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) key_q[i] <= 3'd0;
    end else if ((state_q == S_IDLE) && key_wr) begin
      key_q[key_addr] <= key_data;
    end
  end

  // Only alpha bytes consume a key entry; the index wraps at the latched length.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q     <= 1'b0;
      key_len_q  <= 3'd0;
      msg_len_q  <= 8'd0;
      key_idx_q  <= 3'd0;
      byte_cnt_q <= 8'd0;
    end else if (honour_start) begin
      mode_q     <= mode_in;
      key_len_q  <= key_len;
      msg_len_q  <= msg_len;
      key_idx_q  <= 3'd0;
      byte_cnt_q <= 8'd0;
    end else if (accept) begin
      byte_cnt_q <= byte_cnt_q + 8'd1;
      if (is_upper || is_lower)
        key_idx_q <= (key_idx_q == key_len_q) ? 3'd0 : key_idx_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_en        <= 1'b0;
      pipe_shift_en  <= 1'b0;
      pipe_mode      <= 1'b0;
      pipe_upper     <= 1'b0;
      pipe_lower     <= 1'b0;
      pipe_shift_amt <= 3'd0;
      pipe_data      <= 8'd0;
    end else begin
      pipe_en <= accept;
      if (accept) begin
        pipe_shift_en  <= is_upper || is_lower;
        pipe_mode      <= mode_q;
        pipe_upper     <= is_upper;
        pipe_lower     <= is_lower;
        pipe_shift_amt <= key_q[key_idx_q];
        pipe_data      <= in_data;
      end
    end
  end

endmodule

// File: doc/shift_key_ctrl.md
SHIFT_KEY_CTRL -- requirements
Module: shift_key_ctrl

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  asynchronous active-low reset.
REQ-004 key_wr  input  1  writes key_data into the key entry at key_addr; honoured in IDLE only.
REQ-005 key_addr  input  3  key entry index, 0..7.
REQ-006 key_data  input  3  shift amount to store.
REQ-007 key_len  input  3  number of key entries in use minus 1; sampled on start.
REQ-008 start  input  1  single-cycle pulse that begins a message; honoured in IDLE only.
REQ-009 mode_in  input  1  direction, 1 = decrypt and 0 = encrypt; sampled on start.
REQ-010 msg_len  input  8  message length in bytes; sampled on start.
REQ-011 in_valid  input  1  in_data is valid.
REQ-012 in_data  input  8  ASCII byte.
REQ-013 in_ready  output  1  the controller accepts in_data this cycle.
REQ-014 pipe_en, pipe_shift_en, pipe_mode, pipe_upper, pipe_lower  output  1 each  registered controls to the shift stage.
REQ-015 pipe_shift_amt  output  3  registered shift amount; pipe_data  output  8  registered byte.
REQ-016 busy  output  1  high in RUN and DONE.
REQ-017 done  output  1  single-cycle pulse at message end.

Function
REQ-018 The FSM SHALL have three states, with these transitions:
- IDLE to RUN on start with msg_len != 0.
- RUN to DONE on acceptance of byte number msg_len.
- DONE to IDLE unconditionally after one cycle.
REQ-019 In IDLE, start with msg_len == 0 SHALL be ignored; the FSM stays in IDLE and done stays low.
REQ-020 On an honoured start, the block SHALL latch mode, key_len and msg_len, clear key_idx to 0, and clear the byte counter to 0.
REQ-021 A byte SHALL be accepted in a cycle where in_valid && in_ready; in_ready is low in IDLE and DONE.
REQ-022 An input byte SHALL be classified upper-case when it is 65..90 and lower-case when it is 97..122; all other bytes are non-alpha.
REQ-023 One cycle after each acceptance, the block SHALL drive:
- pipe_en = 1
- pipe_data = in_data
- pipe_upper and pipe_lower = the classification
- pipe_shift_en = upper || lower
- pipe_shift_amt = key[key_idx]
- pipe_mode = the latched mode
REQ-024 In a cycle with no acceptance, pipe_en SHALL be 0 and the other pipe outputs SHALL hold their last values.
REQ-025 key_idx SHALL advance only on acceptance of an alpha byte, wrapping from the latched key_len to 0; non-alpha bytes use key[key_idx] but do not advance it.
REQ-026 The byte counter SHALL increment on every acceptance, regardless of class.
REQ-027 done SHALL be high for exactly the DONE cycle, which is the cycle in which the last byte's pipe_en = 1.
REQ-028 start and key_wr asserted in RUN or DONE SHALL be ignored, with no effect on the key, mode or count.
REQ-029 key_wr and start asserted together in IDLE SHALL take effect together; the key write is visible to the new message from its first byte.
REQ-030 Key entries above the latched key_len SHALL never be selected.

Reset
REQ-031 While rst = 0, the block SHALL hold:
- state = IDLE
- all key entries = 0
- key_idx = 0 and byte counter = 0
- all outputs = 0, including in_ready, busy and done
REQ-032 A reset asserted mid-message SHALL abort the message immediately; after release, the block is in IDLE and needs the key reloaded and a new start.

Configuration
REQ-033 With SHIFT_KEY_CTRL_BACKPRESSURE_EN defined, the block SHALL have an input port pipe_stall (1 bit), and in_ready = (state == RUN) && !pipe_stall.
REQ-034 With SHIFT_KEY_CTRL_BACKPRESSURE_EN undefined, pipe_stall SHALL be absent and in_ready = (state == RUN).

Verification
REQ-035 Basic sequence:
- Stimulus: key[0] = 3, key[1] = 1, key_len = 1, mode_in = 1, msg_len = 3, bytes "AbC" with in_valid held high.
- Required response: pipe_shift_amt = 3, 1, 3; pipe_upper = 1, 0, 1; pipe_lower = 0, 1, 0; done pulses one cycle after the last acceptance.
REQ-036 Non-alpha bytes:
- Stimulus: same key, bytes "A1B".
- Required response: for '1' (49), pipe_shift_en = 0 and pipe_shift_amt = 1; for 'B', pipe_shift_amt = 1 because key_idx did not advance.
REQ-037 Wrap and illegal commands:
- Stimulus: key_len = 0, key[0] = 5, msg_len = 4, "abcd"; pulse start and key_wr mid-message.
- Required response: pipe_shift_amt = 5 for all four bytes; key[0] is unchanged; exactly 4 pipe_en pulses and 1 done pulse.
REQ-038 Zero-length and reset mid-message:
- Stimulus: start with msg_len = 0.
- Required response: the FSM stays in IDLE and busy = 0.
- Stimulus: rst pulsed after the 2nd of 5 bytes.
- Required response: all outputs = 0 and the state is IDLE.
REQ-039 Back-pressure, with SHIFT_KEY_CTRL_BACKPRESSURE_EN defined:
- Stimulus: pipe_stall = 1 for 3 cycles mid-message.
- Required response: in_ready = 0 and pipe_en = 0 for those 3 cycles; the byte order and key sequence are preserved.
